// File: rtl/stage_memory_if.sv
// Data-memory bus between the memory stage (master) and the data memory (slave).
//   req   : access request, held high until ack
//   we    : 1 = write, 0 = read
//   addr  : word-aligned byte address
//   wdata : lane-replicated store data
//   wstrb : byte-lane write strobes, 0000 on reads
//   ack   : completion; rdata is valid in the same cycle
//   rdata : read word
interface stage_memory_if;
    logic        req;
    logic        we;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic [3:0]  wstrb;
    logic        ack;
    logic [31:0] rdata;

    modport master (output req, we, addr, wdata, wstrb, input ack, rdata);
    modport slave  (input req, we, addr, wdata, wstrb, output ack, rdata);
endinterface

// File: rtl/stage_memory.sv
// Memory stage of a 5-stage RISC-V pipeline.
// Issues loads/stores on the data-memory bus with a two-state IDLE/BUSY FSM,
// stalls the front of the pipeline until the access completes, formats store
// lanes/strobes, aligns and extends load data, and registers the pipeline
// passthroughs towards writeback.
//
// Ports:
//   clk, rst                   clock, synchronous active-high reset
//   execute_*                  instruction fields from the execute stage
//   dmem                       data-memory bus (stage_memory_if.master)
//   mem_rd / mem_regfile_wr_enable / mem_result_src / mem_alu_result /
//   mem_instr_addr_plus        registered passthroughs to writeback
//   mem_read_data              registered aligned/extended load result
//   mem_stall                  combinational stall for IF/ID/EX
//   mem_misaligned             one-cycle misaligned-access flag
//
// Optional feature: define MEM_MISALIGN_TRAP_EN to suppress misaligned half/word
// accesses (no bus request, no stall, write-enable dropped, mem_misaligned pulse).
// Without it, offending low address bits are ignored and mem_misaligned is 0.
module stage_memory (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [4:0]            execute_rd,
    input  logic                  execute_regfile_wr_enable,
    input  logic [1:0]            execute_result_src,
    input  logic                  execute_datamem_wr_enable,
    input  logic [2:0]            execute_funct3,
    input  logic [31:0]           execute_alu_result,
    input  logic [31:0]           execute_wr_datamem_data,
    input  logic [31:0]           execute_instr_addr_plus,
    stage_memory_if.master        dmem,
    output logic [4:0]            mem_rd,
    output logic                  mem_regfile_wr_enable,
    output logic [1:0]            mem_result_src,
    output logic [31:0]           mem_alu_result,
    output logic [31:0]           mem_instr_addr_plus,
    output logic [31:0]           mem_read_data,
    output logic                  mem_stall,
    output logic                  mem_misaligned
);
    typedef enum logic {IDLE = 1'b0, BUSY = 1'b1} state_t;
    state_t state, state_nxt;

    logic [1:0]  lo;
    logic        is_load, is_mem, misaligned, trap, start, complete;
    logic [3:0]  st_strb;
    logic [31:0] st_data;

    // Latched access context, stable for the whole BUSY period
    logic        we_q, load_q;
    logic [31:0] addr_q, wdata_q;
    logic [3:0]  wstrb_q;
    logic [2:0]  f3_q;
    logic [1:0]  lo_q;

    logic [7:0]  ld_byte;
    logic [15:0] ld_half;
    logic [31:0] ld_val;

    assign lo      = execute_alu_result[1:0];
    assign is_load = (execute_result_src == 2'b01);
    assign is_mem  = is_load | execute_datamem_wr_enable;

`ifdef MEM_MISALIGN_TRAP_EN
    assign misaligned = ((execute_funct3[1:0] == 2'b01) && lo[0]) ||
                        (execute_funct3[1] && (lo != 2'b00));
`else
    assign misaligned = 1'b0;
`endif

    // Only meaningful in IDLE: in BUSY the execute fields belong to the held access.
    assign trap     = (state == IDLE) && is_mem && misaligned;
    assign start    = (state == IDLE) && is_mem && !misaligned;
    assign complete = (state == BUSY) && dmem.ack;

    always_comb begin
        state_nxt = state;
        mem_stall = 1'b0;
        case (state)
            IDLE: if (start) begin
                mem_stall = 1'b1;
                state_nxt = BUSY;
            end
            BUSY: if (dmem.ack) state_nxt = IDLE;
                  else          mem_stall = 1'b1;
        endcase
    end

    // Store lane formatting; funct3[1:0] gives the size, word is the fallback.
    always_comb begin
        st_strb = 4'b1111;
        st_data = execute_wr_datamem_data;
        case (execute_funct3[1:0])
            2'b00: begin
                st_strb = 4'b0001 << lo;
                st_data = {4{execute_wr_datamem_data[7:0]}};
            end
            2'b01: begin
                st_strb = lo[1] ? 4'b1100 : 4'b0011;
                st_data = {2{execute_wr_datamem_data[15:0]}};
            end
            default: ;
        endcase
    end

    // Load alignment/extension; funct3[2] selects zero-extension.
    always_comb begin
        ld_byte = dmem.rdata[{lo_q, 3'b000} +: 8];
        ld_half = lo_q[1] ? dmem.rdata[31:16] : dmem.rdata[15:0];
        case (f3_q[1:0])
            2'b00:   ld_val = {{24{ld_byte[7] & ~f3_q[2]}}, ld_byte};
            2'b01:   ld_val = {{16{ld_half[15] & ~f3_q[2]}}, ld_half};
            default: ld_val = dmem.rdata;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            we_q    <= 1'b0;
            load_q  <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            wstrb_q <= '0;
            f3_q    <= '0;
            lo_q    <= '0;
        end else begin
            state <= state_nxt;
            if (start) begin
                we_q    <= execute_datamem_wr_enable;
                load_q  <= is_load;
                addr_q  <= {execute_alu_result[31:2], 2'b00};
                wdata_q <= st_data;
                wstrb_q <= execute_datamem_wr_enable ? st_strb : 4'b0000;
                f3_q    <= execute_funct3;
                lo_q    <= lo;
            end
        end
    end

    assign dmem.req   = (state == BUSY);
    assign dmem.we    = we_q;
    assign dmem.addr  = addr_q;
    assign dmem.wdata = wdata_q;
    assign dmem.wstrb = wstrb_q;

    // Stalled edges insert a bubble by clearing only the write enable.
    always_ff @(posedge clk) begin
        if (rst) begin
            mem_rd                <= '0;
            mem_regfile_wr_enable <= 1'b0;
            mem_result_src        <= '0;
            mem_alu_result        <= '0;
            mem_instr_addr_plus   <= '0;
            mem_read_data         <= '0;
        end else begin
            if (mem_stall) begin
                mem_regfile_wr_enable <= 1'b0;
            end else begin
                mem_rd                <= execute_rd;
                mem_regfile_wr_enable <= execute_regfile_wr_enable & ~trap;
                mem_result_src        <= execute_result_src;
                mem_alu_result        <= execute_alu_result;
                mem_instr_addr_plus   <= execute_instr_addr_plus;
            end
            if (complete && load_q) mem_read_data <= ld_val;
        end
    end

`ifdef MEM_MISALIGN_TRAP_EN
    always_ff @(posedge clk) begin
        if (rst) mem_misaligned <= 1'b0;
        else     mem_misaligned <= trap;
    end
`else
    assign mem_misaligned = 1'b0;
`endif
endmodule

// File: tb/tb_stage_memory.sv
module tb_stage_memory;
    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic [4:0]  execute_rd;
    logic        execute_regfile_wr_enable;
    logic [1:0]  execute_result_src;
    logic        execute_datamem_wr_enable;
    logic [2:0]  execute_funct3;
    logic [31:0] execute_alu_result;
    logic [31:0] execute_wr_datamem_data;
    logic [31:0] execute_instr_addr_plus;
    logic [4:0]  mem_rd;
    logic        mem_regfile_wr_enable;
    logic [1:0]  mem_result_src;
    logic [31:0] mem_alu_result;
    logic [31:0] mem_instr_addr_plus;
    logic [31:0] mem_read_data;
    logic        mem_stall;
    logic        mem_misaligned;

    stage_memory_if dmem();

    stage_memory dut (
        .clk                       (clk),
        .rst                       (rst),
        .execute_rd                (execute_rd),
        .execute_regfile_wr_enable (execute_regfile_wr_enable),
        .execute_result_src        (execute_result_src),
        .execute_datamem_wr_enable (execute_datamem_wr_enable),
        .execute_funct3            (execute_funct3),
        .execute_alu_result        (execute_alu_result),
        .execute_wr_datamem_data   (execute_wr_datamem_data),
        .execute_instr_addr_plus   (execute_instr_addr_plus),
        .dmem                      (dmem),
        .mem_rd                    (mem_rd),
        .mem_regfile_wr_enable     (mem_regfile_wr_enable),
        .mem_result_src            (mem_result_src),
        .mem_alu_result            (mem_alu_result),
        .mem_instr_addr_plus       (mem_instr_addr_plus),
        .mem_read_data             (mem_read_data),
        .mem_stall                 (mem_stall),
        .mem_misaligned            (mem_misaligned)
    );

    typedef struct {
        logic [4:0]  rd;
        logic        rfwe;
        logic [1:0]  src;
        logic [31:0] alu;
        logic [31:0] pc4;
        logic [31:0] rdat;
        logic        mis;
    } exp_t;

    typedef struct {
        logic        we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
        logic [31:0] rdata;
        int          delay;
    } plan_t;

    exp_t  exp_q[$];
    plan_t plan_q[$];
    int    n_chk = 0, n_pass = 0;
    logic  mon_en = 1'b0, resp_en = 1'b0, prev_ok = 1'b0;
    logic [31:0] last_load = '0;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got %h want %h", nm, act, exp);
    endtask

    task automatic chk_zero(input string tag);
        chk({tag, "_req"},   dmem.req, 0);
        chk({tag, "_we"},    dmem.we, 0);
        chk({tag, "_addr"},  dmem.addr, 0);
        chk({tag, "_wstrb"}, dmem.wstrb, 0);
        chk({tag, "_rd"},    mem_rd, 0);
        chk({tag, "_rfwe"},  mem_regfile_wr_enable, 0);
        chk({tag, "_src"},   mem_result_src, 0);
        chk({tag, "_alu"},   mem_alu_result, 0);
        chk({tag, "_pc4"},   mem_instr_addr_plus, 0);
        chk({tag, "_rdat"},  mem_read_data, 0);
        chk({tag, "_mis"},   mem_misaligned, 0);
        chk({tag, "_stall"}, mem_stall, 0);
    endtask

    task automatic drive_nop();
        execute_rd = 0; execute_regfile_wr_enable = 0; execute_result_src = 0;
        execute_datamem_wr_enable = 0; execute_funct3 = 0; execute_alu_result = 0;
        execute_wr_datamem_data = 0; execute_instr_addr_plus = 0;
    endtask

    // Drives one instruction, computes its expected effect from the ISA rules,
    // and holds it until the stage accepts it. Returns at posedge+1.
    task automatic issue(input logic [4:0] rd, input logic rfwe, input logic [1:0] src,
                         input logic st, input logic [2:0] f3, input logic [31:0] alu,
                         input logic [31:0] wd, input logic [31:0] pc4,
                         input logic [31:0] rdata, input int delay);
        bit is_ld, is_m, trap;
        int sz, lo, off, ns, sb;
        logic [31:0] mask, wdv, v;
        exp_t e;
        plan_t p;
        execute_rd = rd; execute_regfile_wr_enable = rfwe; execute_result_src = src;
        execute_datamem_wr_enable = st; execute_funct3 = f3; execute_alu_result = alu;
        execute_wr_datamem_data = wd; execute_instr_addr_plus = pc4;

        is_ld = (src == 2'b01);
        is_m  = is_ld || st;
        sz    = (f3[1:0] == 2'b00) ? 1 : (f3[1:0] == 2'b01) ? 2 : 4;
        lo    = int'(alu[1:0]);
        off   = lo - (lo % sz);
        trap  = 0;
`ifdef MEM_MISALIGN_TRAP_EN
        trap  = is_m && (lo % sz != 0);
`endif
        mask = (sz == 4) ? 32'hFFFF_FFFF : ((32'd1 << (8 * sz)) - 32'd1);
        wdv  = '0;
        for (int i = 0; i < 4 / sz; i++) wdv |= (wd & mask) << (8 * sz * i);
        sb   = ((1 << sz) - 1) << off;
        v    = (rdata >> (8 * off)) & mask;
        if (sz < 4 && !f3[2] && v[8 * sz - 1]) v |= ~mask;

        if (is_m && !trap) begin
            p.we = st; p.addr = alu & 32'hFFFF_FFFC; p.wdata = wdv;
            p.wstrb = st ? sb[3:0] : 4'b0000; p.rdata = rdata; p.delay = delay;
            plan_q.push_back(p);
        end
        if (is_ld && !trap) last_load = v;
        e.rd = rd; e.rfwe = rfwe && !trap; e.src = src; e.alu = alu; e.pc4 = pc4;
        e.rdat = last_load; e.mis = trap;

        @(negedge clk); #1;
        ns = 0;
        while (mem_stall && ns < 60) begin
            ns++;
            @(negedge clk); #1;
        end
        if (ns >= 60) chk("stall_timeout", 1, 0);
        chk("stall_cycles", ns, (is_m && !trap) ? delay + 1 : 0);
        exp_q.push_back(e);
        @(posedge clk); #1;
    endtask

    // Monitor: after every accepted edge, compare the registered outputs.
    always begin
        exp_t e;
        @(negedge clk); #1;
        if (mon_en && prev_ok) begin
            if (exp_q.size() == 0) chk("no_expected", 1, 0);
            else begin
                e = exp_q.pop_front();
                chk("mem_rd",   mem_rd, e.rd);
                chk("mem_rfwe", mem_regfile_wr_enable, e.rfwe);
                chk("mem_src",  mem_result_src, e.src);
                chk("mem_alu",  mem_alu_result, e.alu);
                chk("mem_pc4",  mem_instr_addr_plus, e.pc4);
                chk("mem_rdat", mem_read_data, e.rdat);
                chk("mem_mis",  mem_misaligned, e.mis);
            end
        end else if (mon_en) begin
            chk("bubble_rfwe", mem_regfile_wr_enable, 0);
        end
        prev_ok = mon_en && !mem_stall && !rst;
    end

    // Memory responder: checks each request against the plan and acks after the planned delay.
    always begin
        static plan_t p;
        static bit in_acc = 0, have_p = 0;
        static int cnt = 0;
        @(negedge clk);
        if (resp_en) begin
            if (dmem.req) begin
                if (!in_acc) begin
                    in_acc = 1; cnt = 0;
                    if (plan_q.size() == 0) begin
                        chk("unexpected_req", 1, 0);
                        have_p = 0;
                    end else begin
                        p = plan_q.pop_front();
                        have_p = 1;
                        chk("dmem_addr",  dmem.addr, p.addr);
                        chk("dmem_we",    dmem.we, p.we);
                        chk("dmem_wstrb", dmem.wstrb, p.wstrb);
                        if (p.we) chk("dmem_wdata", dmem.wdata, p.wdata);
                    end
                end else if (have_p) begin
                    chk("hold_addr",  dmem.addr, p.addr);
                    chk("hold_wstrb", dmem.wstrb, p.wstrb);
                end
                if (have_p && cnt == p.delay) begin
                    dmem.ack = 1'b1; dmem.rdata = p.rdata;
                end else begin
                    dmem.ack = !have_p && cnt > 2; dmem.rdata = $urandom;
                end
                cnt++;
            end else begin
                // Spurious ack while idle must be ignored.
                in_acc = 0;
                dmem.ack = ($urandom_range(0, 3) == 0);
                dmem.rdata = $urandom;
            end
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] src;
        logic st, rfwe;
        logic [2:0] f3;
        dmem.ack = 1'b0; dmem.rdata = '0;
        rst = 1'b1;
        drive_nop();
        repeat (3) @(posedge clk);
        #1;
        chk_zero("reset");
        rst = 1'b0;
        resp_en = 1'b1;
        @(posedge clk); #1;
        mon_en = 1'b1;

        // Directed cases
        issue(5'd0, 0, 2'b00, 1, 3'b010, 32'h100, 32'hDEADBEEF, 32'h1004, 32'h0, 3); // SW
        issue(5'd0, 0, 2'b00, 1, 3'b000, 32'h103, 32'h000000A5, 32'h1008, 32'h0, 0); // SB
        issue(5'd3, 1, 2'b01, 0, 3'b000, 32'h202, 32'h0, 32'h100C, 32'h12F45678, 1); // LB
        issue(5'd4, 1, 2'b01, 0, 3'b100, 32'h202, 32'h0, 32'h1010, 32'h12F45678, 0); // LBU
        issue(5'd6, 1, 2'b01, 0, 3'b101, 32'h202, 32'h0, 32'h1014, 32'h12F45678, 2); // LHU
        issue(5'd5, 1, 2'b00, 0, 3'b000, 32'h0000_0042, 32'h0, 32'h1018, 32'h0, 0);  // ADD
        issue(5'd8, 1, 2'b10, 0, 3'b000, 32'h0000_0077, 32'h0, 32'h101C, 32'h0, 0);  // JAL
        issue(5'd9, 1, 2'b01, 0, 3'b010, 32'h101, 32'h0, 32'h1020, 32'hCAFEF00D, 1); // LW misaligned
        issue(5'd0, 0, 2'b00, 1, 3'b001, 32'h2FF, 32'h0000BEEF, 32'h1024, 32'h0, 0); // SH misaligned

        // Randomized traffic
        for (int n = 0; n < 150; n++) begin
            case ($urandom_range(0, 2))
                0: src = 2'b00;
                1: src = 2'b01;
                default: src = 2'b10;
            endcase
            st   = (src != 2'b01) && ($urandom_range(0, 2) == 0);
            rfwe = st ? 1'b0 : 1'($urandom);
            f3   = st ? 3'($urandom_range(0, 2)) : 3'($urandom_range(0, 7));
            issue(5'($urandom), rfwe, src, st, f3, $urandom, $urandom, $urandom,
                  $urandom, $urandom_range(0, 4));
        end
        @(negedge clk); #2;
        mon_en = 1'b0;
        chk("exp_drained", exp_q.size(), 0);
        chk("plan_drained", plan_q.size(), 0);

        // Reset while BUSY, then a late ack
        @(posedge clk); #1;
        resp_en = 1'b0;
        dmem.ack = 1'b0;
        execute_rd = 5'd7; execute_regfile_wr_enable = 1; execute_result_src = 2'b01;
        execute_datamem_wr_enable = 0; execute_funct3 = 3'b010;
        execute_alu_result = 32'h300; execute_instr_addr_plus = 32'h2000;
        repeat (2) @(posedge clk);
        #1;
        chk("busy_req", dmem.req, 1);
        chk("busy_stall", mem_stall, 1);
        rst = 1'b1;
        drive_nop();
        @(posedge clk); #1;
        rst = 1'b0;
        chk_zero("rst_busy");
        dmem.ack = 1'b1; dmem.rdata = 32'hFFFF_FFFF;
        @(posedge clk); #1;
        dmem.ack = 1'b0;
        chk_zero("late_ack");

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
